// File: rtl/rv32_hart_pc_ctrl.sv
// Per-hart PC controller for the barrel core: round-robin fetch issue and branch/jump resolve.
// Optional misaligned-target trap enabled by defining RV32_PC_MISALIGN_EN.
package rv32_hart_pc_ctrl_pkg;
    typedef enum logic [3:0] {
        OP_OTHER = 4'd0,
        OP_ADD   = 4'd1,
        OP_BEQ   = 4'd2,
        OP_BNE   = 4'd3,
        OP_BLT   = 4'd4,
        OP_BGE   = 4'd5,
        OP_BLTU  = 4'd6,
        OP_BGEU  = 4'd7,
        OP_JAL   = 4'd8,
        OP_JALR  = 4'd9,
        OP_AUIPC = 4'd10,
        OP_LUI   = 4'd11,
        OP_LOAD  = 4'd12,
        OP_STORE = 4'd13
    } rv32_opcode_enum_t;
endpackage

module rv32_hart_pc_ctrl
    import rv32_hart_pc_ctrl_pkg::*;
#(
    parameter int              NUM_HARTS = 8,
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_PC   = 32'h0000_0010,
    localparam int             HW        = $clog2(NUM_HARTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_HARTS-1:0] hart_en,
    output logic                 fetch_valid,
    input  logic                 fetch_ready,
    output logic [HW-1:0]        fetch_hart,
    output logic [XLEN-1:0]      fetch_pc,
    input  logic                 res_valid,
    input  logic [HW-1:0]        res_hart,
    input  rv32_opcode_enum_t    res_opcode,
    input  logic [XLEN-1:0]      res_pc,
    input  logic [XLEN-1:0]      res_alu,
    input  logic [XLEN-1:0]      res_rs1,
    input  logic [XLEN-1:0]      res_imm,
    output logic                 wb_valid,
    output logic [HW-1:0]        wb_hart,
    output logic [XLEN-1:0]      wb_val,
    output logic                 redirect,
    output logic                 trap
);

    logic [XLEN-1:0]      r_pc [NUM_HARTS];
    logic [NUM_HARTS-1:0] r_busy;
    logic [HW-1:0]        r_rr;
    logic                 r_hold;
    logic [HW-1:0]        r_hold_hart;

    logic [NUM_HARTS-1:0] w_elig;
    logic                 w_arb_vld;
    logic [HW-1:0]        w_arb_hart;
    logic [HW-1:0]        w_idx;
    logic                 w_issue;

    logic                 w_acc;
    logic                 w_is_br;
    logic                 w_is_jal;
    logic                 w_is_jalr;
    logic                 w_is_auipc;
    logic [XLEN-1:0]      w_seq;
    logic [XLEN-1:0]      w_rel;
    logic [XLEN-1:0]      w_jr;
    logic [XLEN-1:0]      w_next;
    logic [XLEN-1:0]      w_link;
    logic                 w_wb;
    logic                 w_jump;
    logic                 w_mis;
    logic [XLEN-1:0]      w_final;
    logic                 w_unused;

    assign w_unused = ^res_alu[XLEN-1:1];

    // Lowest offset from the rr pointer wins, so scan from the far end.
    always_comb begin
        w_elig     = hart_en & ~r_busy;
        w_arb_vld  = 1'b0;
        w_arb_hart = '0;
        w_idx      = '0;
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            w_idx = r_rr + HW'(i);
            if (w_elig[w_idx]) begin
                w_arb_vld  = 1'b1;
                w_arb_hart = w_idx;
            end
        end
    end

    // A stalled offer stays pinned to the same hart until accepted.
    assign fetch_valid = r_hold | w_arb_vld;
    assign fetch_hart  = r_hold ? r_hold_hart : w_arb_hart;
    assign fetch_pc    = r_pc[fetch_hart];
    assign w_issue     = fetch_valid & fetch_ready;

    assign w_acc      = res_valid & r_busy[res_hart];
    assign w_is_br    = res_opcode inside {OP_BEQ, OP_BNE, OP_BLT,
                                           OP_BGE, OP_BLTU, OP_BGEU};
    assign w_is_jal   = (res_opcode == OP_JAL);
    assign w_is_jalr  = (res_opcode == OP_JALR);
    assign w_is_auipc = (res_opcode == OP_AUIPC);

    assign w_seq = res_pc + XLEN'(4);
    assign w_rel = res_pc + (res_imm << 1);
    assign w_jr  = (res_rs1 + res_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};

    always_comb begin
        w_next = w_seq;
        w_link = '0;
        w_wb   = 1'b0;
        w_jump = 1'b0;
        unique case (1'b1)
            w_is_br: begin
                if (res_alu[0]) begin
                    w_next = w_rel;
                    w_jump = 1'b1;
                end
            end
            w_is_jal: begin
                w_next = w_rel;
                w_link = w_seq;
                w_wb   = 1'b1;
                w_jump = 1'b1;
            end
            w_is_jalr: begin
                w_next = w_jr;
                w_link = w_seq;
                w_wb   = 1'b1;
                w_jump = 1'b1;
            end
            w_is_auipc: begin
                w_link = res_pc + res_imm;
                w_wb   = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef RV32_PC_MISALIGN_EN
    assign w_mis = w_jump & (w_next[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    assign w_final = w_mis ? TRAP_PC : w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_pc[h] <= RESET_PC;
            end
        end else if (w_acc) begin
            r_pc[res_hart] <= w_final;
        end
    end

    // Issue and accepted resolve never target the same hart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= '0;
            r_rr        <= '0;
            r_hold      <= 1'b0;
            r_hold_hart <= '0;
        end else begin
            if (w_issue) begin
                r_busy[fetch_hart] <= 1'b1;
                r_rr               <= fetch_hart + HW'(1);
            end
            if (w_acc) begin
                r_busy[res_hart] <= 1'b0;
            end
            r_hold      <= fetch_valid & ~fetch_ready;
            r_hold_hart <= fetch_hart;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_hart  <= '0;
            wb_val   <= '0;
            redirect <= 1'b0;
            trap     <= 1'b0;
        end else begin
            wb_valid <= w_acc & w_wb & ~w_mis;
            redirect <= w_acc & w_jump;
            trap     <= w_acc & w_mis;
            if (w_acc) begin
                wb_hart <= res_hart;
                wb_val  <= w_link;
            end
        end
    end

endmodule

// File: tb/tb_rv32_hart_pc_ctrl.sv
// Directed bench for rv32_hart_pc_ctrl: vector table of resolves plus
// hand-written issue/resolve/reset corner sequences.
module tb_rv32_hart_pc_ctrl;
    import rv32_hart_pc_ctrl_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [7:0]        hart_en;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [2:0]        fetch_hart;
    logic [31:0]       fetch_pc;
    logic              res_valid;
    logic [2:0]        res_hart;
    rv32_opcode_enum_t res_opcode;
    logic [31:0]       res_pc;
    logic [31:0]       res_alu;
    logic [31:0]       res_rs1;
    logic [31:0]       res_imm;
    logic              wb_valid;
    logic [2:0]        wb_hart;
    logic [31:0]       wb_val;
    logic              redirect;
    logic              trap;

    rv32_hart_pc_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hart_en     (hart_en),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_hart  (fetch_hart),
        .fetch_pc    (fetch_pc),
        .res_valid   (res_valid),
        .res_hart    (res_hart),
        .res_opcode  (res_opcode),
        .res_pc      (res_pc),
        .res_alu     (res_alu),
        .res_rs1     (res_rs1),
        .res_imm     (res_imm),
        .wb_valid    (wb_valid),
        .wb_hart     (wb_hart),
        .wb_val      (wb_val),
        .redirect    (redirect),
        .trap        (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]        hart;
        rv32_opcode_enum_t op;
        logic [31:0]       pc;
        logic [31:0]       alu;
        logic [31:0]       rs1;
        logic [31:0]       imm;
        logic              ewb;
        logic [31:0]       ewbval;
        logic              eredir;
        logic              etrap;
        logic [31:0]       enext;
    } vec_t;

    vec_t vecs[9];
    int   n_chk;
    int   n_fail;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_res(input logic [2:0] h, input rv32_opcode_enum_t op,
                             input logic [31:0] pc, input logic [31:0] alu,
                             input logic [31:0] rs1, input logic [31:0] imm);
        res_valid  = 1'b1;
        res_hart   = h;
        res_opcode = op;
        res_pc     = pc;
        res_alu    = alu;
        res_rs1    = rs1;
        res_imm    = imm;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{3'd3, OP_ADD,  32'h40,       32'h0, 32'h0,    32'h0,
                    1'b0, 32'h0,   1'b0, 1'b0, 32'h44};
        vecs[1] = '{3'd2, OP_BEQ,  32'h100,      32'h1, 32'h0,    32'h8,
                    1'b0, 32'h0,   1'b1, 1'b0, 32'h110};
        vecs[2] = '{3'd2, OP_BEQ,  32'h100,      32'h0, 32'h0,    32'h8,
                    1'b0, 32'h0,   1'b0, 1'b0, 32'h104};
        vecs[3] = '{3'd5, OP_JALR, 32'h300,      32'h0, 32'h2001, 32'h4,
                    1'b1, 32'h304, 1'b1, 1'b0, 32'h2004};
        vecs[4] = '{3'd5, OP_JAL,  32'h80,       32'h0, 32'h0,    32'h10,
                    1'b1, 32'h84,  1'b1, 1'b0, 32'hA0};
        vecs[5] = '{3'd6, OP_AUIPC, 32'h1000,    32'h0, 32'h0,    32'h3000,
                    1'b1, 32'h4000, 1'b0, 1'b0, 32'h1004};
        vecs[6] = '{3'd7, OP_BNE,  32'hFFFF_FFF8, 32'h1, 32'h0,   32'h8,
                    1'b0, 32'h0,   1'b1, 1'b0, 32'h8};
`ifdef RV32_PC_MISALIGN_EN
        vecs[7] = '{3'd4, OP_JALR, 32'h500,      32'h0, 32'h2000, 32'h2,
                    1'b0, 32'h0,   1'b1, 1'b1, 32'h10};
`else
        vecs[7] = '{3'd4, OP_JALR, 32'h500,      32'h0, 32'h2000, 32'h2,
                    1'b1, 32'h504, 1'b1, 1'b0, 32'h2002};
`endif
        vecs[8] = '{3'd1, OP_BLT,  32'h200,      32'h1, 32'h0, 32'hFFFF_FFFC,
                    1'b0, 32'h0,   1'b1, 1'b0, 32'h1F8};

        rst_n       = 1'b0;
        hart_en     = 8'h00;
        fetch_ready = 1'b0;
        drive_res(3'd0, OP_OTHER, 32'h0, 32'h0, 32'h0, 32'h0);
        res_valid   = 1'b0;
        #12;

        chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        chk("rst_fetch_hart",  32'(fetch_hart),  32'h0);
        chk("rst_fetch_pc",    fetch_pc,         32'h0);
        chk("rst_wb_valid",    32'(wb_valid),    32'h0);
        chk("rst_wb_hart",     32'(wb_hart),     32'h0);
        chk("rst_wb_val",      wb_val,           32'h0);
        chk("rst_redirect",    32'(redirect),    32'h0);
        chk("rst_trap",        32'(trap),        32'h0);

        rst_n       = 1'b1;
        hart_en     = 8'hFF;
        fetch_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("init_valid", 32'(fetch_valid), 32'h1);
            chk("init_hart",  32'(fetch_hart),  32'(i));
            chk("init_pc",    fetch_pc,         32'h0);
            tick();
        end
        chk("init_all_busy", 32'(fetch_valid), 32'h0);
        fetch_ready = 1'b0;

        for (int v = 0; v < 9; v++) begin
            drive_res(vecs[v].hart, vecs[v].op, vecs[v].pc,
                      vecs[v].alu, vecs[v].rs1, vecs[v].imm);
            tick();
            res_valid = 1'b0;
            chk("vec_wb_valid", 32'(wb_valid), 32'(vecs[v].ewb));
            chk("vec_redirect", 32'(redirect), 32'(vecs[v].eredir));
            chk("vec_trap",     32'(trap),     32'(vecs[v].etrap));
            if (vecs[v].ewb) begin
                chk("vec_wb_hart", 32'(wb_hart), 32'(vecs[v].hart));
                chk("vec_wb_val",  wb_val,       vecs[v].ewbval);
            end
            chk("vec_fetch_valid", 32'(fetch_valid), 32'h1);
            chk("vec_fetch_hart",  32'(fetch_hart),  32'(vecs[v].hart));
            chk("vec_next_pc",     fetch_pc,         vecs[v].enext);
            fetch_ready = 1'b1;
            tick();
            fetch_ready = 1'b0;
            chk("vec_reissued", 32'(fetch_valid), 32'h0);
        end

        // Resolve to a hart that is already idle must be ignored.
        drive_res(3'd3, OP_ADD, 32'h44, 32'h0, 32'h0, 32'h0);
        tick();
        res_valid = 1'b0;
        chk("idle_prep_pc", fetch_pc, 32'h48);
        drive_res(3'd3, OP_JAL, 32'h900, 32'h0, 32'h0, 32'h100);
        tick();
        res_valid = 1'b0;
        chk("idle_redirect", 32'(redirect),   32'h0);
        chk("idle_wb_valid", 32'(wb_valid),   32'h0);
        chk("idle_hart",     32'(fetch_hart), 32'h3);
        chk("idle_pc",       fetch_pc,        32'h48);

        // Issue of hart 3 and resolve of hart 0 in the same cycle.
        chk("same_pre_hart", 32'(fetch_hart), 32'h3);
        fetch_ready = 1'b1;
        drive_res(3'd0, OP_ADD, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        res_valid   = 1'b0;
        fetch_ready = 1'b0;
        chk("same_valid", 32'(fetch_valid), 32'h1);
        chk("same_hart",  32'(fetch_hart),  32'h0);
        chk("same_pc",    fetch_pc,         32'h4);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        chk("same_all_busy", 32'(fetch_valid), 32'h0);

        // hart_en dropped while hart 0 is in flight.
        hart_en = 8'hFE;
        drive_res(3'd0, OP_ADD, 32'h4, 32'h0, 32'h0, 32'h0);
        tick();
        res_valid = 1'b0;
        chk("dis_no_issue", 32'(fetch_valid), 32'h0);
        hart_en = 8'hFF;
        #1;
        chk("dis_valid", 32'(fetch_valid), 32'h1);
        chk("dis_hart",  32'(fetch_hart),  32'h0);
        chk("dis_pc",    fetch_pc,         32'h8);

        // Stalled offer stays on hart 0 even when hart 1 becomes eligible.
        drive_res(3'd1, OP_ADD, 32'h1F8, 32'h0, 32'h0, 32'h0);
        tick();
        res_valid = 1'b0;
        chk("stall_hart0", 32'(fetch_hart), 32'h0);
        chk("stall_pc0",   fetch_pc,        32'h8);
        tick();
        chk("stall_hart1", 32'(fetch_hart), 32'h0);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        chk("stall_next_hart", 32'(fetch_hart), 32'h1);
        chk("stall_next_pc",   fetch_pc,        32'h1FC);

        // Asynchronous reset with instructions in flight.
        drive_res(3'd2, OP_JAL, 32'h40, 32'h0, 32'h0, 32'h40);
        res_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",    32'(fetch_valid), 32'h1);
        chk("arst_hart",     32'(fetch_hart),  32'h0);
        chk("arst_pc",       fetch_pc,         32'h0);
        chk("arst_redirect", 32'(redirect),    32'h0);
        tick();
        rst_n = 1'b1;
        drive_res(3'd2, OP_JAL, 32'h40, 32'h0, 32'h0, 32'h40);
        tick();
        res_valid = 1'b0;
        chk("arst_discard_redirect", 32'(redirect), 32'h0);
        chk("arst_discard_wb",       32'(wb_valid), 32'h0);
        chk("arst_post_hart",        32'(fetch_hart), 32'h0);
        chk("arst_post_pc",          fetch_pc,        32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
